cv32e40p_fetch_addr_sequencer: RTL and testbench
================================================

Name: cv32e40p_fetch_addr_sequencer

Overview:
- Fetch-side consumer of the IF-stage redirect produced by the PC-selection logic.
- Takes a redirect (pc_set_i, branch_addr_i) and drives sequential word-aligned instruction fetches on an OBI-style instruction bus.
- Buffers returned words with their addresses in a small response FIFO. Discards in-flight responses belonging to a stream that a redirect has superseded.
- Sits between the PC mux and the instruction decoder/aligner.

Parameters:
DEPTH, 2, maximum of outstanding bus transactions plus buffered FIFO entries; also the FIFO depth; DEPTH ≥ 1.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
pc_set_i  input  1  redirect strobe, one cycle
branch_addr_i  input  32  redirect target; bits [1:0] ignored
instr_req_o  output  1  bus request
instr_addr_o  output  32  bus address, always word-aligned
instr_gnt_i  input  1  bus grant; request accepted when instr_req_o & instr_gnt_i
instr_rvalid_i  input  1  response valid, in order, at least one cycle after grant
instr_rdata_i  input  32  response data
fetch_valid_o  output  1  FIFO head valid
fetch_rdata_o  output  32  FIFO head instruction word
fetch_addr_o  output  32  FIFO head address
fetch_ready_i  input  1  consumer pops head when fetch_valid_o & fetch_ready_i
busy_o  output  1  outstanding != 0, FIFO non-empty, or state != IDLE

Behaviour:
- Reset (rst=1 at edge):
  - State IDLE; FIFO empty; outstanding=0; discard=0; next_addr=0.
  - All outputs read 0: instr_req_o, instr_addr_o, fetch_valid_o, fetch_rdata_o, fetch_addr_o, busy_o.
  - Reset mid-transaction abandons all counters. Any late rvalid after reset is counted as a normal response only if outstanding > 0, which it is not, so it is ignored.
- States: IDLE, RUN, HOLD.
  - IDLE: instr_req_o=0. pc_set_i → RUN with next_addr={branch_addr_i[31:2],2'b00}. No fetch before the first redirect (boot).
  - RUN:
    - instr_req_o=1 iff outstanding + fifo_count < DEPTH; instr_addr_o=next_addr.
    - On grant: outstanding++ and next_addr += 4, wrapping modulo 2^32 (0xFFFFFFFC → 0x00000000).
  - HOLD: entered when pc_set_i arrives while instr_req_o=1 and instr_gnt_i=0.
    - Bus rule: req and addr stay stable until granted. The old request stays asserted with its old address.
    - Redirect target latched into pending_addr.
    - On grant: outstanding++, discard++, next_addr=pending_addr, → RUN.
    - A further pc_set_i in HOLD overwrites pending_addr.
- Redirect in RUN or HOLD, effective at the same edge as pc_set_i:
  - FIFO flushed, including a pop occurring that cycle.
  - discard = outstanding after this cycle's grant/rvalid updates.
  - If the request was granted in the same cycle, that transaction is included in discard.
  - Redirect in the same cycle as an ungranted request → HOLD. Otherwise next_addr = new target, state RUN.
- Responses, on rvalid:
  - outstanding--.
  - If discard > 0: drop the word, discard--.
  - Else: push {addr, rdata}. addr comes from a FIFO-parallel in-flight address queue of depth DEPTH, pushed at grant and popped at rvalid.
  - rvalid in the same cycle as pc_set_i belongs to the old stream and is never pushed.
- FIFO: fetch_valid_o = !empty; head outputs are zero when empty.
  - Push and pop in the same cycle keep the count.
  - Push when full cannot occur because of the credit rule; assert on it.
- Errors:
  - rvalid with outstanding=0 is a protocol violation; assert, no state change.

Test Plan:
- Boot: rst 3 cycles, pc_set_i with branch_addr_i=0x0000_1083, gnt tied 1, rvalid 1 cycle after each grant, fetch_ready_i=1 → addresses 0x1080, 0x1084, 0x1088; fetch_addr_o follows the same sequence with matching data; no req before pc_set_i.
- Backpressure: fetch_ready_i=0 with DEPTH=2 → exactly 2 grants (0x2000, 0x2004), then instr_req_o=0 with FIFO full; raising ready for one cycle → one pop, one new request 0x2008.
- Redirect with 2 outstanding: grants at 0x3000/0x3004, pc_set_i to 0x4000 before either rvalid → both responses dropped, next request 0x4000, first fetch_addr_o=0x4000.
- Redirect during ungranted request: req at 0x5000 with gnt=0, pc_set_i to 0x6000 → addr stays 0x5000 until gnt; its response is dropped; next request 0x6000.
- Wrap: redirect to 0xFFFF_FFF8 → requests 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Reset mid-run: rst asserted with 1 outstanding and FIFO non-empty → next cycle all outputs 0, state IDLE; a subsequent stray rvalid is ignored.

Source files
------------

// File: rtl/cv32e40p_fetch_addr_sequencer.sv
// Fetch address sequencer: turns PC redirects into sequential word fetches on an
// OBI-style instruction bus and buffers returned words, dropping superseded responses.
module cv32e40p_fetch_addr_sequencer #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_set_i,
    input  logic [31:0] branch_addr_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_rdata_o,
    output logic [31:0] fetch_addr_o,
    input  logic        fetch_ready_i,
    output logic        busy_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_e;

    state_e        state_q, state_d;
    logic [31:0]   next_addr_q, next_addr_d;
    logic [31:0]   pending_addr_q, pending_addr_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] fl_wr_ptr_q, fl_wr_ptr_d, fl_rd_ptr_q, fl_rd_ptr_d;

    logic [31:0]   fifo_addr_q [DEPTH];
    logic [31:0]   fifo_data_q [DEPTH];
    logic [31:0]   fl_addr_q   [DEPTH];

    logic [31:0]   target;
    logic [CW:0]   credit_used;
    logic          grant, rsp, drop, redirect, push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign target      = branch_addr_i & 32'hFFFF_FFFC;
    assign credit_used = (CW+1)'(outstanding_q) + (CW+1)'(count_q);

    always_comb begin
        instr_req_o = 1'b0;
        case (state_q)
            RUN:     instr_req_o = (credit_used < (CW+1)'(DEPTH));
            HOLD:    instr_req_o = 1'b1;
            default: instr_req_o = 1'b0;
        endcase
    end

    assign instr_addr_o  = next_addr_q;
    assign grant         = instr_req_o & instr_gnt_i;
    // A response with nothing outstanding is stray and must not touch any state.
    assign rsp           = instr_rvalid_i & (outstanding_q != '0);
    assign drop          = rsp & (discard_q != '0);
    assign redirect      = pc_set_i & (state_q != IDLE);
    assign push          = rsp & ~drop & ~pc_set_i;
    assign fetch_valid_o = (count_q != '0);
    assign pop           = fetch_valid_o & fetch_ready_i & ~pc_set_i;
    assign fetch_rdata_o = fetch_valid_o ? fifo_data_q[rd_ptr_q] : '0;
    assign fetch_addr_o  = fetch_valid_o ? fifo_addr_q[rd_ptr_q] : '0;
    assign busy_o        = (outstanding_q != '0) | fetch_valid_o | (state_q != IDLE);

    always_comb begin
        state_d        = state_q;
        next_addr_d    = next_addr_q;
        pending_addr_d = pending_addr_q;
        outstanding_d  = outstanding_q + CW'(grant) - CW'(rsp);
        discard_d      = discard_q - CW'(drop);
        case (state_q)
            IDLE: begin
                if (pc_set_i) begin
                    state_d     = RUN;
                    next_addr_d = target;
                end
            end
            RUN: begin
                if (grant) next_addr_d = next_addr_q + 32'd4;
            end
            HOLD: begin
                // The held request belongs to the old stream, so its response is dropped.
                if (grant) begin
                    discard_d   = discard_d + CW'(1);
                    next_addr_d = pending_addr_q;
                    state_d     = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
        if (redirect) begin
            discard_d = outstanding_d;
            if (instr_req_o && !instr_gnt_i) begin
                state_d        = HOLD;
                pending_addr_d = target;
            end else begin
                state_d     = RUN;
                next_addr_d = target;
            end
        end
    end

    always_comb begin
        count_d     = count_q + CW'(push) - CW'(pop);
        wr_ptr_d    = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d    = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        fl_wr_ptr_d = grant ? ptr_inc(fl_wr_ptr_q) : fl_wr_ptr_q;
        fl_rd_ptr_d = rsp ? ptr_inc(fl_rd_ptr_q) : fl_rd_ptr_q;
        if (pc_set_i) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            next_addr_q    <= '0;
            pending_addr_q <= '0;
            outstanding_q  <= '0;
            discard_q      <= '0;
            count_q        <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            fl_wr_ptr_q    <= '0;
            fl_rd_ptr_q    <= '0;
        end else begin
            state_q        <= state_d;
            next_addr_q    <= next_addr_d;
            pending_addr_q <= pending_addr_d;
            outstanding_q  <= outstanding_d;
            discard_q      <= discard_d;
            count_q        <= count_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            fl_wr_ptr_q    <= fl_wr_ptr_d;
            fl_rd_ptr_q    <= fl_rd_ptr_d;
        end
    end

    // Storage arrays carry no reset; validity is tracked by the counters above.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= fl_addr_q[fl_rd_ptr_q];
            fifo_data_q[wr_ptr_q] <= instr_rdata_i;
        end
        if (grant) fl_addr_q[fl_wr_ptr_q] <= instr_addr_o;
    end

    // Late responses while idle are leftovers of transactions abandoned by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && (count_q == CW'(DEPTH))))
                else $error("response buffer overflow");
            assert (!(instr_rvalid_i && (outstanding_q == '0) && (state_q != IDLE)))
                else $error("rvalid with no outstanding transaction");
        end
    end
endmodule

// File: tb/tb_cv32e40p_fetch_addr_sequencer.sv
// Bench for cv32e40p_fetch_addr_sequencer: directed scenarios then random traffic,
// compared every cycle against a queue-based reference model and a simple bus responder.
`timescale 1ns/1ps
module tb_cv32e40p_fetch_addr_sequencer;
    localparam int DEPTH = 2;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HOLD = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_set_i = 1'b0;
    logic [31:0] branch_addr_i = '0;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i = 1'b0;
    logic        instr_rvalid_i = 1'b0;
    logic [31:0] instr_rdata_i = '0;
    logic        fetch_valid_o;
    logic [31:0] fetch_rdata_o;
    logic [31:0] fetch_addr_o;
    logic        fetch_ready_i = 1'b0;
    logic        busy_o;

    always #5 clk = ~clk;

    cv32e40p_fetch_addr_sequencer #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_set_i       (pc_set_i),
        .branch_addr_i  (branch_addr_i),
        .instr_req_o    (instr_req_o),
        .instr_addr_o   (instr_addr_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .fetch_valid_o  (fetch_valid_o),
        .fetch_rdata_o  (fetch_rdata_o),
        .fetch_addr_o   (fetch_addr_o),
        .fetch_ready_i  (fetch_ready_i),
        .busy_o         (busy_o)
    );

    typedef struct packed { logic [31:0] addr; logic stale; } flight_t;
    typedef struct packed { logic [31:0] addr; logic [31:0] data; } word_t;
    typedef struct packed { logic [31:0] data; logic [31:0] gcyc; } bus_t;

    flight_t     m_fl[$];
    word_t       m_fifo[$];
    bus_t        bus_q[$];
    logic [31:0] granted[$];
    logic [31:0] fetched[$];
    int          m_mode = M_IDLE;
    logic [31:0] m_next = '0;
    logic [31:0] m_pend = '0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] cyc_n = '0;

    function automatic logic m_req();
        if (m_mode == M_HOLD) return 1'b1;
        if (m_mode == M_RUN) return (m_fl.size() + m_fifo.size()) < DEPTH;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        word_t h;
        logic  v;
        v = (m_fifo.size() > 0);
        h = '0;
        if (v) h = m_fifo[0];
        chk("instr_req", {31'b0, instr_req_o}, {31'b0, m_req()});
        chk("instr_addr", instr_addr_o, m_next);
        chk("fetch_valid", {31'b0, fetch_valid_o}, {31'b0, v});
        chk("fetch_rdata", fetch_rdata_o, h.data);
        chk("fetch_addr", fetch_addr_o, h.addr);
        chk("busy", {31'b0, busy_o}, {31'b0, (m_fl.size() > 0) || v || (m_mode != M_IDLE)});
    endtask

    task automatic model_step(input logic pc, input logic [31:0] ba, input logic gnt,
                              input logic rv, input logic [31:0] rd, input logic rdy);
        logic        req;
        logic [31:0] tgt;
        flight_t     f;
        word_t       w;
        req = m_req();
        tgt = {ba[31:2], 2'b00};
        if (m_fifo.size() > 0 && rdy && !pc) void'(m_fifo.pop_front());
        if (rv && m_fl.size() > 0) begin
            f = m_fl.pop_front();
            if (!f.stale && !pc) begin
                w.addr = f.addr;
                w.data = rd;
                m_fifo.push_back(w);
            end
        end
        if (req && gnt) begin
            f.addr  = m_next;
            f.stale = (m_mode == M_HOLD);
            m_fl.push_back(f);
        end
        if (pc) begin
            m_fifo.delete();
            foreach (m_fl[i]) m_fl[i].stale = 1'b1;
            if (req && !gnt) begin
                m_mode = M_HOLD;
                m_pend = tgt;
            end else begin
                m_mode = M_RUN;
                m_next = tgt;
            end
        end else if (req && gnt) begin
            if (m_mode == M_HOLD) begin
                m_next = m_pend;
                m_mode = M_RUN;
            end else begin
                m_next = m_next + 32'd4;
            end
        end
    endtask

    // rvm: 0 = no response, 1 = respond if a granted transaction is due, 2 = stray rvalid
    task automatic cyc(input logic pc, input logic [31:0] ba, input logic gnt,
                       input logic rdy, input int rvm);
        logic        rv, grant_exp;
        logic [31:0] rd;
        bus_t        b;
        rv = 1'b0;
        rd = $urandom;
        if (rvm == 1 && bus_q.size() > 0 && bus_q[0].gcyc < cyc_n) begin
            rv = 1'b1;
            rd = bus_q[0].data;
        end else if (rvm == 2) begin
            rv = 1'b1;
        end
        pc_set_i       = pc;
        branch_addr_i  = ba;
        instr_gnt_i    = gnt;
        fetch_ready_i  = rdy;
        instr_rvalid_i = rv;
        instr_rdata_i  = rd;
        grant_exp      = m_req() && gnt;
        #1;
        if (instr_req_o && gnt) granted.push_back(instr_addr_o);
        if (fetch_valid_o && rdy && !pc) fetched.push_back(fetch_addr_o);
        @(posedge clk);
        if (rv && rvm == 1) void'(bus_q.pop_front());
        if (grant_exp) begin
            b.data = $urandom;
            b.gcyc = cyc_n;
            bus_q.push_back(b);
        end
        model_step(pc, ba, gnt, rv, rd, rdy);
        cyc_n = cyc_n + 1;
        #1;
        check_all();
    endtask

    task automatic do_reset(input int n);
        rst            = 1'b1;
        pc_set_i       = 1'b0;
        branch_addr_i  = '0;
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = '0;
        fetch_ready_i  = 1'b0;
        repeat (n) @(posedge clk);
        m_fl.delete();
        m_fifo.delete();
        bus_q.delete();
        m_mode = M_IDLE;
        m_next = '0;
        m_pend = '0;
        cyc_n  = cyc_n + n;
        #1;
        rst = 1'b0;
        check_all();
        granted.delete();
        fetched.delete();
    endtask

    initial begin
        // Boot: no request before the first redirect, then sequential words.
        do_reset(3);
        repeat (3) cyc(1'b0, 32'h0, 1'b1, 1'b1, 1);
        chk("boot_no_req", 32'(granted.size()), 32'd0);
        cyc(1'b1, 32'h0000_1083, 1'b1, 1'b1, 1);
        repeat (10) cyc(1'b0, 32'h0, 1'b1, 1'b1, 1);
        chk("boot_g0", granted[0], 32'h1080);
        chk("boot_g1", granted[1], 32'h1084);
        chk("boot_g2", granted[2], 32'h1088);
        chk("boot_f0", fetched[0], 32'h1080);
        chk("boot_f1", fetched[1], 32'h1084);
        chk("boot_f2", fetched[2], 32'h1088);
        $display("boot: %0d grants, %0d fetches", granted.size(), fetched.size());

        // Backpressure: credit stops at DEPTH, one pop frees exactly one request.
        do_reset(2);
        cyc(1'b1, 32'h2000, 1'b1, 1'b0, 1);
        repeat (8) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1);
        chk("bp_ngrants", 32'(granted.size()), 32'd2);
        chk("bp_g0", granted[0], 32'h2000);
        chk("bp_g1", granted[1], 32'h2004);
        chk("bp_req_off", {31'b0, instr_req_o}, 32'd0);
        chk("bp_full", {31'b0, fetch_valid_o}, 32'd1);
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1);
        chk("bp_req_on", {31'b0, instr_req_o}, 32'd1);
        chk("bp_addr", instr_addr_o, 32'h2008);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1);
        chk("bp_g2", granted[2], 32'h2008);
        $display("backpressure: %0d grants, %0d pops", granted.size(), fetched.size());

        // Redirect while two responses are still outstanding.
        do_reset(2);
        cyc(1'b1, 32'h3000, 1'b1, 1'b0, 0);
        repeat (4) cyc(1'b0, 32'h0, 1'b1, 1'b0, 0);
        cyc(1'b1, 32'h4000, 1'b0, 1'b0, 0);
        repeat (10) cyc(1'b0, 32'h0, 1'b1, 1'b1, 1);
        chk("rd_g0", granted[0], 32'h3000);
        chk("rd_g1", granted[1], 32'h3004);
        chk("rd_g2", granted[2], 32'h4000);
        chk("rd_f0", fetched[0], 32'h4000);
        $display("redirect: first fetch %h", fetched[0]);

        // Redirect against an ungranted request holds the old address.
        do_reset(2);
        cyc(1'b1, 32'h5000, 1'b0, 1'b1, 1);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1);
        cyc(1'b1, 32'h6000, 1'b0, 1'b1, 1);
        repeat (2) cyc(1'b0, 32'h0, 1'b0, 1'b1, 1);
        chk("hold_req", {31'b0, instr_req_o}, 32'd1);
        chk("hold_addr", instr_addr_o, 32'h5000);
        repeat (10) cyc(1'b0, 32'h0, 1'b1, 1'b1, 1);
        chk("hold_g0", granted[0], 32'h5000);
        chk("hold_g1", granted[1], 32'h6000);
        chk("hold_f0", fetched[0], 32'h6000);
        $display("hold: grants %h %h", granted[0], granted[1]);

        // Address wrap past the top of memory.
        do_reset(2);
        cyc(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1, 1);
        repeat (10) cyc(1'b0, 32'h0, 1'b1, 1'b1, 1);
        chk("wrap_g0", granted[0], 32'hFFFF_FFF8);
        chk("wrap_g1", granted[1], 32'hFFFF_FFFC);
        chk("wrap_g2", granted[2], 32'h0000_0000);
        $display("wrap: grants %h %h %h", granted[0], granted[1], granted[2]);

        // Reset with one outstanding and a buffered word, then a stray response.
        do_reset(2);
        cyc(1'b1, 32'h7000, 1'b1, 1'b0, 0);
        repeat (2) cyc(1'b0, 32'h0, 1'b1, 1'b0, 0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1);
        chk("mid_valid", {31'b0, fetch_valid_o}, 32'd1);
        do_reset(1);
        chk("rst_req", {31'b0, instr_req_o}, 32'd0);
        chk("rst_addr", instr_addr_o, 32'd0);
        chk("rst_valid", {31'b0, fetch_valid_o}, 32'd0);
        chk("rst_busy", {31'b0, busy_o}, 32'd0);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 2);
        chk("stray_valid", {31'b0, fetch_valid_o}, 32'd0);
        chk("stray_busy", {31'b0, busy_o}, 32'd0);
        $display("reset mid-run: busy=%0b valid=%0b", busy_o, fetch_valid_o);

        // Random traffic against the reference model.
        do_reset(2);
        for (int i = 0; i < 3000; i++) begin
            logic        pc, gnt, rdy;
            logic [31:0] ba;
            int          rvm;
            pc  = ($urandom_range(0, 15) == 0);
            ba  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                              : 32'($urandom);
            gnt = ($urandom_range(0, 2) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            rvm = ($urandom_range(0, 2) != 0) ? 1 : 0;
            if ($urandom_range(0, 499) == 0) do_reset(1 + $urandom_range(0, 2));
            else cyc(pc, ba, gnt, rdy, rvm);
        end
        $display("random: %0d checks so far", checks);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
